ccc_apb_cfg_master: RTL and testbench

APB initiator for the SmartFusion2 fabric CCC dynamic-configuration port. It turns single read/write commands from fabric control logic into CCC APB cycles (PSEL/PENABLE/PWRITE/PADDR/PWDATA, PRDATA), waits out the CCC's BUSY flag, and optionally waits for the PLL to re-lock after a write. It sits between a system controller or soft-CPU register bank and the CCC APB pins. The controller uses it to retune GL0/GL1 at runtime without regenerating the CCC.

---
 rtl/ccc_cfg_pkg.sv | 35 +++
 rtl/lock_sync2.sv | 29 ++
 rtl/ccc_apb_cfg_master.sv | 210 +++++++++++++++++++++
 tb/tb_ccc_apb_cfg_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccc_cfg_pkg.sv
// Shared types and constants for the CCC dynamic-configuration APB master.
// Contents: FSM state encoding, latched-command payload, CCC bus widths,
// named CCC register addresses and a counter-width helper.
package ccc_cfg_pkg;

  localparam int unsigned CCC_ADDR_W = 6;
  localparam int unsigned CCC_DATA_W = 8;

  // CCC configuration registers touched when retuning the output clocks
  localparam logic [CCC_ADDR_W-1:0] CCC_REG_GL0_DIV = 6'h03;
  localparam logic [CCC_ADDR_W-1:0] CCC_REG_GL1_DIV = 6'h06;
  localparam logic [CCC_ADDR_W-1:0] CCC_REG_FB_DIV  = 6'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT_BUSY,
    ST_WAIT_LOCK,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                  write;
    logic                  wait_lock;
    logic [CCC_ADDR_W-1:0] addr;
    logic [CCC_DATA_W-1:0] wdata;
  } cmd_t;

  // Bits needed to hold 0..max_val, never less than one
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_sync2.sv
// Two-flop synchronizer for asynchronous CCC status signals (e.g. LOCK).
// Ports:
//   clk   in  destination clock
//   reset in  synchronous active-high reset, output resets to 0
//   d_i   in  asynchronous input
//   q_o   out synchronized output
module lock_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ccc_apb_cfg_master.sv
// APB initiator for the fabric CCC dynamic-configuration port. Runs one
// read or write per command, waits for CCC BUSY to drop after a write and
// optionally for the PLL to re-lock, then returns a response.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/cmd_wait_lock        command kind and lock-wait request
//   cmd_addr/cmd_wdata             CCC register address and write data
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err              read data (0 on writes), timeout flag
//   ccc_preset_n                   CCC PRESET_N
//   ccc_psel/penable/pwrite/paddr/pwdata, ccc_prdata   CCC APB pins
//   ccc_busy                       CCC BUSY (synchronous)
//   ccc_lock                       CCC LOCK (asynchronous)
//   lock_o                         synchronized LOCK
module ccc_apb_cfg_master
  import ccc_cfg_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 255,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_wait_lock,
  input  logic [CCC_ADDR_W-1:0] cmd_addr,
  input  logic [CCC_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CCC_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  ccc_preset_n,
  output logic                  ccc_psel,
  output logic                  ccc_penable,
  output logic                  ccc_pwrite,
  output logic [CCC_ADDR_W-1:0] ccc_paddr,
  output logic [CCC_DATA_W-1:0] ccc_pwdata,
  input  logic [CCC_DATA_W-1:0] ccc_prdata,
  input  logic                  ccc_busy,
  input  logic                  ccc_lock,
  output logic                  lock_o
);

  localparam int unsigned BUSY_W   = cnt_width(BUSY_TIMEOUT);
  localparam int unsigned LOCKTO_W = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned STABLE_W = cnt_width(LOCK_STABLE);

  state_e                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [BUSY_W-1:0]     busy_cnt_q, busy_cnt_d;
  logic [LOCKTO_W-1:0]   lock_to_q, lock_to_d;
  logic [STABLE_W-1:0]   stable_q, stable_d;
  logic [STABLE_W-1:0]   stable_nxt_c;
  logic                  cmd_hs_c;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [CCC_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [CCC_ADDR_W-1:0] paddr_q, paddr_d;
  logic [CCC_DATA_W-1:0] pwdata_q, pwdata_d;
  logic                  preset_n_q;

  // LOCK crosses from the PLL domain
  lock_sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (ccc_lock),
    .q_o   (lock_o)
  );

  // cmd_ready_q is only ever high in IDLE and never during reset
  assign cmd_hs_c = cmd_valid & cmd_ready_q;

  // Next-state logic; every output register is derived from the next state
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    busy_cnt_d   = busy_cnt_q;
    lock_to_d    = lock_to_q;
    stable_d     = stable_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    stable_nxt_c = lock_o ? ((&stable_q) ? stable_q : stable_q + STABLE_W'(1))
                          : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hs_c) begin
          cmd_d       = '{write: cmd_write, wait_lock: cmd_wait_lock,
                          addr: cmd_addr, wdata: cmd_wdata};
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (cmd_q.write) begin
          busy_cnt_d = '0;
          state_d    = ST_WAIT_BUSY;
        end else begin
          rsp_rdata_d = ccc_prdata;
          state_d     = ST_RESP;
        end
      end
      ST_WAIT_BUSY: begin
        if (!ccc_busy) begin
          if (cmd_q.wait_lock) begin
            lock_to_d = '0;
            stable_d  = '0;
            state_d   = ST_WAIT_LOCK;
          end else begin
            state_d = ST_RESP;
          end
        end else if (busy_cnt_q == BUSY_W'(BUSY_TIMEOUT)) begin
          rsp_err_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          busy_cnt_d = (&busy_cnt_q) ? busy_cnt_q : busy_cnt_q + BUSY_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Stable count includes the current cycle; lock wins over timeout
        stable_d = stable_nxt_c;
        if (stable_nxt_c == STABLE_W'(LOCK_STABLE)) begin
          state_d = ST_RESP;
        end else if (lock_to_q == LOCKTO_W'(LOCK_TIMEOUT)) begin
          rsp_err_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          lock_to_d = (&lock_to_q) ? lock_to_q : lock_to_q + LOCKTO_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    pwrite_d    = psel_d & cmd_d.write;
    paddr_d     = psel_d ? cmd_d.addr  : '0;
    pwdata_d    = psel_d ? cmd_d.wdata : '0;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      busy_cnt_q  <= '0;
      lock_to_q   <= '0;
      stable_q    <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      busy_cnt_q  <= busy_cnt_d;
      lock_to_q   <= lock_to_d;
      stable_q    <= stable_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  // CCC held in reset for the same cycles as this block, released one edge later
  always_ff @(posedge clk) begin
    preset_n_q <= ~reset;
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign ccc_preset_n = preset_n_q;
  assign ccc_psel     = psel_q;
  assign ccc_penable  = penable_q;
  assign ccc_pwrite   = pwrite_q;
  assign ccc_paddr    = paddr_q;
  assign ccc_pwdata   = pwdata_q;

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Directed self-checking bench for ccc_apb_cfg_master.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ccc_apb_cfg_master;
  import ccc_cfg_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic                  cmd_wait_lock;
  logic [CCC_ADDR_W-1:0] cmd_addr;
  logic [CCC_DATA_W-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [CCC_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  ccc_preset_n;
  logic                  ccc_psel;
  logic                  ccc_penable;
  logic                  ccc_pwrite;
  logic [CCC_ADDR_W-1:0] ccc_paddr;
  logic [CCC_DATA_W-1:0] ccc_pwdata;
  logic [CCC_DATA_W-1:0] ccc_prdata;
  logic                  ccc_busy;
  logic                  ccc_lock;
  logic                  lock_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ccc_apb_cfg_master #(
    .BUSY_TIMEOUT (16),
    .LOCK_TIMEOUT (100),
    .LOCK_STABLE  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_wait_lock (cmd_wait_lock),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .ccc_preset_n  (ccc_preset_n),
    .ccc_psel      (ccc_psel),
    .ccc_penable   (ccc_penable),
    .ccc_pwrite    (ccc_pwrite),
    .ccc_paddr     (ccc_paddr),
    .ccc_pwdata    (ccc_pwdata),
    .ccc_prdata    (ccc_prdata),
    .ccc_busy      (ccc_busy),
    .ccc_lock      (ccc_lock),
    .lock_o        (lock_o)
  );

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one command at a falling edge; returns at the SETUP sample point
  task automatic send_cmd(input logic wr, input logic wl,
                          input logic [CCC_ADDR_W-1:0] a,
                          input logic [CCC_DATA_W-1:0] d);
    check_eq("ready_before_cmd", 16'(cmd_ready), 16'd1);
    cmd_valid     = 1'b1;
    cmd_write     = wr;
    cmd_wait_lock = wl;
    cmd_addr      = a;
    cmd_wdata     = d;
    tick();
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_wait_lock = 1'b0;
    cmd_addr      = '0;
    cmd_wdata     = '0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", 16'(rsp_valid), 16'd0);
    check_eq("ready_after_rsp", 16'(cmd_ready), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int bad;
    reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_wait_lock = 1'b0;
    cmd_addr = CCC_REG_FB_DIV; cmd_wdata = '0; rsp_ready = 1'b0;
    ccc_prdata = '0; ccc_busy = 1'b0; ccc_lock = 1'b0;

    // Reset state, with cmd_valid held high and ignored
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", 16'(cmd_ready), 16'd0);
    check_eq("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check_eq("rst_rsp_rdata", 16'(rsp_rdata), 16'd0);
    check_eq("rst_rsp_err", 16'(rsp_err), 16'd0);
    check_eq("rst_preset_n", 16'(ccc_preset_n), 16'd0);
    check_eq("rst_apb", 16'({ccc_psel, ccc_penable, ccc_pwrite, ccc_paddr, ccc_pwdata}), 16'd0);
    check_eq("rst_lock_o", 16'(lock_o), 16'd0);
    reset = 1'b0; cmd_valid = 1'b0;
    tick();
    check_eq("rel_preset_n", 16'(ccc_preset_n), 16'd1);
    check_eq("rel_cmd_ready", 16'(cmd_ready), 16'd1);
    check_eq("rel_no_psel", 16'(ccc_psel), 16'd0);

    // Read FB_DIV returning 0x5C
    ccc_prdata = 8'h5C;
    send_cmd(1'b0, 1'b0, CCC_REG_FB_DIV, 8'h00);
    check_eq("rd_setup_sel_en", 16'({ccc_psel, ccc_penable, ccc_pwrite}), 16'b100);
    check_eq("rd_setup_addr", 16'(ccc_paddr), 16'h0A);
    check_eq("rd_setup_ready", 16'(cmd_ready), 16'd0);
    tick();
    check_eq("rd_access_sel_en", 16'({ccc_psel, ccc_penable}), 16'b11);
    check_eq("rd_access_addr", 16'(ccc_paddr), 16'h0A);
    tick();
    check_eq("rd_rsp_valid", 16'(rsp_valid), 16'd1);
    check_eq("rd_rsp_rdata", 16'(rsp_rdata), 16'h5C);
    check_eq("rd_rsp_err", 16'(rsp_err), 16'd0);
    check_eq("rd_rsp_apb_idle", 16'({ccc_psel, ccc_penable, ccc_paddr}), 16'd0);
    consume();

    // Write GL0_DIV <= 0xA7 with BUSY high for ten cycles
    ccc_busy = 1'b1;
    send_cmd(1'b1, 1'b0, CCC_REG_GL0_DIV, 8'hA7);
    check_eq("wr_setup_ctl", 16'({ccc_psel, ccc_penable, ccc_pwrite}), 16'b101);
    check_eq("wr_setup_addr", 16'(ccc_paddr), 16'h03);
    check_eq("wr_setup_wdata", 16'(ccc_pwdata), 16'hA7);
    tick();
    check_eq("wr_access_ctl", 16'({ccc_psel, ccc_penable, ccc_pwrite}), 16'b111);
    check_eq("wr_access_wdata", 16'(ccc_pwdata), 16'hA7);
    tick();
    check_eq("wr_busy_apb_idle", 16'({ccc_psel, ccc_penable, ccc_pwrite, ccc_pwdata}), 16'd0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid !== 1'b0) bad++;
      tick();
    end
    check_eq("wr_no_rsp_while_busy", 16'(bad), 16'd0);
    ccc_busy = 1'b0;
    tick();
    check_eq("wr_rsp_valid", 16'(rsp_valid), 16'd1);
    check_eq("wr_rsp_err", 16'(rsp_err), 16'd0);
    check_eq("wr_rsp_rdata_zero", 16'(rsp_rdata), 16'd0);
    consume();

    // BUSY stuck high: 17 WAIT_BUSY cycles then error response
    ccc_busy = 1'b1;
    send_cmd(1'b1, 1'b0, CCC_REG_GL1_DIV, 8'h11);
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (rsp_valid !== 1'b0) bad++;
    end
    check_eq("bto_no_early_rsp", 16'(bad), 16'd0);
    tick();
    check_eq("bto_rsp_valid", 16'(rsp_valid), 16'd1);
    check_eq("bto_rsp_err", 16'(rsp_err), 16'd1);
    ccc_busy = 1'b0;
    consume();
    check_eq("bto_err_cleared", 16'(rsp_err), 16'd0);

    // Write with lock wait: LOCK 1-0-1 then stable high
    send_cmd(1'b1, 1'b1, CCC_REG_FB_DIV, 8'h42);
    tick();
    tick();
    tick();
    for (int i = 0; i <= 8; i++) begin
      if (i == 3) check_eq("lk_sync_low", 16'(lock_o), 16'd0);
      if (i == 4) check_eq("lk_sync_high", 16'(lock_o), 16'd1);
      if (i == 7) check_eq("lk_no_early_rsp", 16'(rsp_valid), 16'd0);
      if (i == 8) begin
        check_eq("lk_rsp_valid", 16'(rsp_valid), 16'd1);
        check_eq("lk_rsp_err", 16'(rsp_err), 16'd0);
      end
      ccc_lock = (i == 1) ? 1'b0 : 1'b1;
      if (i < 8) tick();
    end
    ccc_lock = 1'b0;
    consume();

    // Write with lock wait and LOCK held low: timeout after 101 cycles
    tick();
    tick();
    send_cmd(1'b1, 1'b1, CCC_REG_GL0_DIV, 8'h55);
    tick();
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid !== 1'b0) bad++;
      tick();
    end
    check_eq("lto_no_early_rsp", 16'(bad), 16'd0);
    tick();
    check_eq("lto_rsp_valid", 16'(rsp_valid), 16'd1);
    check_eq("lto_rsp_err", 16'(rsp_err), 16'd1);
    consume();

    // Reset pulsed during ACCESS
    ccc_prdata = 8'h99;
    send_cmd(1'b0, 1'b0, CCC_REG_GL1_DIV, 8'h00);
    tick();
    check_eq("mr_in_access", 16'({ccc_psel, ccc_penable}), 16'b11);
    reset = 1'b1;
    tick();
    check_eq("mr_apb_dropped", 16'({ccc_psel, ccc_penable}), 16'd0);
    check_eq("mr_rsp_valid", 16'(rsp_valid), 16'd0);
    check_eq("mr_preset_low", 16'(ccc_preset_n), 16'd0);
    check_eq("mr_cmd_ready", 16'(cmd_ready), 16'd0);
    reset = 1'b0;
    tick();
    check_eq("mr_preset_high", 16'(ccc_preset_n), 16'd1);
    check_eq("mr_ready_back", 16'(cmd_ready), 16'd1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0 || ccc_psel !== 1'b0) bad++;
      tick();
    end
    check_eq("mr_no_rsp_after", 16'(bad), 16'd0);

    // Response held while rsp_ready stays low
    ccc_prdata = 8'h3E;
    send_cmd(1'b0, 1'b0, CCC_REG_GL0_DIV, 8'h00);
    tick();
    tick();
    ccc_prdata = 8'hC1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3E || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0) bad++;
      tick();
    end
    check_eq("hold_rsp_stable", 16'(bad), 16'd0);
    check_eq("hold_rdata", 16'(rsp_rdata), 16'h3E);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
